icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Miss-handling controller for the instruction cache in the fetch stage. It watches the cache's `hit`/`miss` for the current fetch PC, stalls the pipeline on a miss, and issues a block-aligned request to instruction memory. When memory returns the 8-word block, it pulses the cache's `update`. Also owns the address fed to the cache during a refill, handles branch flushes mid-refill, and keeps hit/miss performance counters.

## Interface
- `BLOCK_BYTES`, 32: cache block size in bytes; power of two.
- `CNT_WIDTH`, 32: width of each performance counter.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `pc` in 32: fetch PC from the PC register.
- `fetch_en` in 1: a fetch is being attempted this cycle.
- `flush` in 1: branch/jump redirect; the current fetch is abandoned.
- `hit` in 1: from cache; valid for `cache_pc`.
- `miss` in 1: from cache; always `!hit`.
- `cache_pc` out 32: address driven to the cache.
- `stall` out 1: holds PC and IF/ID.
- `update` out 1: one-cycle pulse; the cache writes on the following negedge.
- `mem_req` out 1: block request to instruction memory.
- `mem_addr` out 32: block-aligned request address.
- `mem_valid` in 1: memory block data (w0..w7) is valid this cycle.
- `hit_count` out `CNT_WIDTH`: number of counted hits.
- `miss_count` out `CNT_WIDTH`: number of counted misses.

## Operation
- States: IDLE, REQ, FILL, DRAIN.
- IDLE:
  - `cache_pc = pc`.
  - If `fetch_en && miss && !flush`: capture `miss_addr = {pc[31:5],5'b0}`, increment `miss_count`, go to REQ.
  - If `fetch_en && hit`: increment `hit_count`.
  - If `flush` is asserted: no transition and no count.
- REQ:
  - `mem_req=1`, `mem_addr=miss_addr`, `cache_pc=miss_addr`.
  - `mem_valid` → FILL.
  - `flush` without `mem_valid` → DRAIN.
  - `flush` with `mem_valid` → FILL; the block is still valid for its own index.
- FILL: `update=1`, `cache_pc=miss_addr`, `mem_req=0`, then → IDLE unconditionally.
- DRAIN: `mem_req=1` is held until `mem_valid`, then → IDLE with no `update`. The response is discarded.
- `stall = (state!=IDLE) || (fetch_en && miss && !flush)`. This is combinational in IDLE.
- `mem_valid` is ignored in IDLE and FILL.
- Counters wrap modulo 2^`CNT_WIDTH`.
- Reset values:
  - state is IDLE.
  - `miss_addr`, `mem_addr`, `hit_count` and `miss_count` are 0.
  - `mem_req`, `update` and `stall` are 0 (`stall` is 0 when `fetch_en` is low).
- Reset mid-refill returns the controller to IDLE immediately. A late `mem_valid` is then ignored and no `update` is issued.

## Timing
- Cycle t: IDLE miss, and `stall` rises in the same cycle.
- Cycle t+1: REQ, with `mem_req` high.
- Memory asserts `mem_valid` L≥0 cycles after REQ entry. L=0 means `mem_valid` is already high in cycle t+1.
- Cycle t+1+L is the last REQ cycle. FILL occupies cycle t+2+L, and the cache line is written at that cycle's negedge.
- Cycle t+3+L: IDLE, `hit` is high, `stall` low, and the instruction is delivered.
- Miss penalty is L+3 cycles of `stall`.
- `mem_addr` is stable for the whole request. `mem_req` drops in the cycle after `mem_valid` is sampled.
- Back-to-back misses: the IDLE cycle after FILL may miss again; there is no dead cycle beyond IDLE.

## Structure
- Shared package `icache_pkg` holds:
  - `refill_state_t` enum {IDLE, REQ, FILL, DRAIN}
  - `BLOCK_OFFSET_BITS` (5)
  - `NOP_INSTR` (32'h00000013), shared with the cache
- Sub-module `event_counter` (parameter `CNT_WIDTH`; inputs `CLK`, `RST`, `inc`; output `count`) is instantiated twice.

## Test plan
- Cold miss:
  - Stimulus: reset, then `fetch_en=1`, `pc=0x0000_0044`, `miss=1`; memory returns L=2.
  - Response: `mem_addr=0x0000_0040`. `stall` is high for 5 cycles. `update` pulses once, in the 5th cycle. `miss_count=1`.
- Hit stream:
  - Stimulus: after a fill, fetch 8 sequential PCs 0x40..0x5C with `hit=1`.
  - Response: `stall=0` throughout, `hit_count=8`, `mem_req` never asserted.
- Flush during REQ:
  - Stimulus: miss at 0x100, then `flush` on the first REQ cycle, with `mem_valid` 3 cycles later.
  - Response: enters DRAIN, no `update`, IDLE one cycle after `mem_valid`, `cache_pc` follows `pc`.
- Reset mid-refill:
  - Stimulus: `RST` asserted in REQ, then `mem_valid` pulsed after release.
  - Response: state IDLE, counters 0, no `update`, `mem_req=0`.
- Zero-latency memory and wrap:
  - Stimulus: `mem_valid` tied high; `miss_count` preloaded near max (`CNT_WIDTH=4`) with two misses.
  - Response: `stall` is high for 3 cycles per miss, and `miss_count` goes 0xF→0x0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache and its refill controller.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } refill_state_t;

    localparam int          BLOCK_OFFSET_BITS = 5;
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;

endpackage

// File: rtl/event_counter.sv
// Free-running event counter; wraps modulo 2^CNT_WIDTH.
module event_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: stalls fetch, requests a block, pulses update.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int BLOCK_BYTES = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          pc,
    input  logic                 fetch_en,
    input  logic                 flush,
    input  logic                 hit,
    input  logic                 miss,
    output logic [31:0]          cache_pc,
    output logic                 stall,
    output logic                 update,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_valid,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam logic [31:0] BLOCK_MASK = ~(32'(BLOCK_BYTES) - 32'd1);

    function automatic logic [31:0] block_align(input logic [31:0] addr);
        return addr & BLOCK_MASK;
    endfunction

    refill_state_t state, state_nxt;
    logic [31:0]   miss_addr;
    logic          fetch_miss;
    logic          fetch_hit;

    // Only an unflushed fetch in IDLE is counted or starts a refill.
    always_comb begin
        fetch_miss = (state == IDLE) && fetch_en && miss && !flush;
        fetch_hit  = (state == IDLE) && fetch_en && hit  && !flush;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state <= state_nxt;
            if (fetch_miss) begin
                miss_addr <= block_align(pc);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cache_pc  = pc;
        update    = 1'b0;
        mem_req   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fetch_miss) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req  = 1'b1;
                cache_pc = miss_addr;
                // A response arriving with the flush still belongs to this index, so fill it.
                if (mem_valid) begin
                    state_nxt = FILL;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            FILL: begin
                update    = 1'b1;
                cache_pc  = miss_addr;
                state_nxt = IDLE;
            end
            DRAIN: begin
                // Abandoned request: wait out the response and drop it.
                mem_req = 1'b1;
                if (mem_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        stall    = (state != IDLE) || fetch_miss;
        mem_addr = miss_addr;
    end

    event_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_hit_counter (
        .CLK  (CLK),
        .RST  (RST),
        .inc  (fetch_hit),
        .count(hit_count)
    );

    event_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_miss_counter (
        .CLK  (CLK),
        .RST  (RST),
        .inc  (fetch_miss),
        .count(miss_count)
    );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed and randomized bench for icache_refill_ctrl with a transaction-level model.
module tb_icache_refill_ctrl;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [31:0]   pc;
    logic          fetch_en;
    logic          flush;
    logic          hit;
    logic          miss;
    logic [31:0]   cache_pc;
    logic          stall;
    logic          update;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_valid;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int checks = 0;
    int passes = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    icache_refill_ctrl #(
        .BLOCK_BYTES(32),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .pc        (pc),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .hit       (hit),
        .miss      (miss),
        .cache_pc  (cache_pc),
        .stall     (stall),
        .update    (update),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hits"},   32'(hit_count),  32'(exp_hits   % (1 << CW)));
        check({tag, "_misses"}, 32'(miss_count), 32'(exp_misses % (1 << CW)));
    endtask

    // One full miss: the IDLE miss cycle, lat+1 REQ cycles, then FILL (or DRAIN if
    // flushed before the response), followed by one IDLE hit cycle on the same PC.
    task automatic do_miss(input logic [31:0] a, input int lat, input int fk, input bit tie);
        logic [31:0] blk;
        int stalls;
        int upd;
        bit drained;
        blk = a & 32'hFFFF_FFE0;
        stalls = 0;
        upd = 0;
        drained = 0;
        pc = a; fetch_en = 1'b1; hit = 1'b0; miss = 1'b1; flush = 1'b0; mem_valid = tie;
        #1;
        check("miss_stall", 32'(stall), 32'd1);
        check("miss_cpc", cache_pc, a);
        check("miss_req", 32'(mem_req), 32'd0);
        stalls += int'(stall);
        upd += int'(update);
        exp_misses++;
        step();
        for (int k = 0; k <= lat; k++) begin
            pc = drained ? $urandom : a;
            fetch_en = 1'($urandom);
            hit = 1'($urandom);
            miss = !hit;
            mem_valid = tie || (k == lat);
            flush = (k == fk);
            #1;
            check("req_mem_req", 32'(mem_req), 32'd1);
            check("req_mem_addr", mem_addr, blk);
            check("req_cpc", cache_pc, drained ? pc : blk);
            stalls += int'(stall);
            upd += int'(update);
            if (k == fk && k < lat) drained = 1'b1;
            step();
        end
        if (!drained) begin
            pc = $urandom; fetch_en = 1'($urandom); hit = 1'($urandom); miss = !hit;
            flush = 1'($urandom); mem_valid = 1'($urandom) || tie;
            #1;
            check("fill_update", 32'(update), 32'd1);
            check("fill_mem_req", 32'(mem_req), 32'd0);
            check("fill_cpc", cache_pc, blk);
            stalls += int'(stall);
            upd += int'(update);
            step();
        end
        pc = a; fetch_en = 1'b1; hit = 1'b1; miss = 1'b0; flush = 1'b0;
        mem_valid = 1'($urandom) || tie;
        #1;
        check("post_stall", 32'(stall), 32'd0);
        check("post_update", 32'(update), 32'd0);
        check("post_mem_req", 32'(mem_req), 32'd0);
        check("post_cpc", cache_pc, a);
        exp_hits++;
        check("stall_cycles", 32'(stalls), drained ? 32'(lat + 2) : 32'(lat + 3));
        check("update_pulses", 32'(upd), drained ? 32'd0 : 32'd1);
        step();
        check_counts("after_miss");
    endtask

    // An IDLE cycle that never starts a refill (no fetch, hit, or flushed fetch).
    task automatic idle_cycle();
        pc = $urandom; fetch_en = 1'($urandom); hit = 1'($urandom); miss = !hit;
        flush = hit ? 1'($urandom) : 1'b1;
        mem_valid = 1'($urandom);
        #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_mem_req", 32'(mem_req), 32'd0);
        check("idle_update", 32'(update), 32'd0);
        check("idle_cpc", cache_pc, pc);
        if (fetch_en && hit && !flush) exp_hits++;
        step();
    endtask

    initial begin
        RST = 1'b1; pc = 32'h1234_5678; fetch_en = 1'b0; flush = 1'b0;
        hit = 1'b0; miss = 1'b1; mem_valid = 1'b0;
        step();
        step();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_update", 32'(update), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_cpc", cache_pc, 32'h1234_5678);
        check_counts("rst");
        RST = 1'b0;

        // Cold miss with L=2.
        do_miss(32'h0000_0044, 2, -1, 1'b0);

        // Sequential hit stream inside the filled block.
        for (int i = 0; i < 8; i++) begin
            pc = 32'h40 + 32'(4 * i); fetch_en = 1'b1; hit = 1'b1; miss = 1'b0;
            flush = 1'b0; mem_valid = 1'b0;
            #1;
            check("stream_stall", 32'(stall), 32'd0);
            check("stream_mem_req", 32'(mem_req), 32'd0);
            exp_hits++;
            step();
        end
        check_counts("stream");

        // Flush on the first REQ cycle, response three cycles later.
        do_miss(32'h0000_0100, 3, 0, 1'b0);
        // Flush coincident with the response still fills.
        do_miss(32'h0000_0208, 1, 1, 1'b0);

        // Reset while in REQ, then a stray response.
        pc = 32'h0000_0300; fetch_en = 1'b1; hit = 1'b0; miss = 1'b1; flush = 1'b0;
        mem_valid = 1'b0;
        step();
        fetch_en = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        mem_valid = 1'b1;
        #1;
        check("rstmid_stall", 32'(stall), 32'd0);
        check("rstmid_mem_req", 32'(mem_req), 32'd0);
        check("rstmid_update", 32'(update), 32'd0);
        check("rstmid_mem_addr", mem_addr, 32'd0);
        step();
        mem_valid = 1'b0;
        #1;
        check("rstmid_update2", 32'(update), 32'd0);
        check("rstmid_stall2", 32'(stall), 32'd0);
        check_counts("rstmid");

        // Zero-latency memory: drive the miss counter up to and across its wrap.
        while ((exp_misses % (1 << CW)) != 15) do_miss(32'h0000_1000 + 32'(exp_misses * 64), 0, -1, 1'b1);
        check("wrap_max", 32'(miss_count), 32'hF);
        do_miss(32'h0000_2000, 0, -1, 1'b1);
        check("wrap_zero", 32'(miss_count), 32'h0);
        do_miss(32'h0000_2040, 0, -1, 1'b1);
        check("wrap_one", 32'(miss_count), 32'h1);

        // Randomized mix of idle cycles and misses with random latency and flushes.
        for (int n = 0; n < 60; n++) begin
            int lat;
            int fk;
            if ($urandom_range(0, 2) != 0) begin
                idle_cycle();
            end else begin
                lat = int'($urandom_range(0, 4));
                fk = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 4));
                do_miss($urandom, lat, fk, 1'b0);
            end
        end
        check_counts("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
